// File: rtl/vec_switch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vec_switch_arbiter
// Brief    : Central scheduler for the inter-core vector switch. Matches
//            sender/receiver pairs that name each other, grants one transfer
//            at a time with round-robin priority over receivers, and delivers
//            the sender payload on a shared registered bus with one-cycle
//            completion pulses to both parties.
// Options  : VEC_SWITCH_STATS_EN adds xfer_count / stall_count outputs.
// Revision : 1.0 - initial release
// ============================================================================
module vec_switch_arbiter #(
  parameter int CORE_SIZE    = 4,
  parameter int SWITCH_WIDTH = 16,
  parameter int LANE_BITS    = 32,
  parameter int ADDR_SIZE    = $clog2(CORE_SIZE)
) (
  input  logic                                      clock,
  input  logic                                      reset,
  input  logic [CORE_SIZE-1:0]                      send_ready,
  input  logic [CORE_SIZE*ADDR_SIZE-1:0]            send_core_idx,
  input  logic [CORE_SIZE*SWITCH_WIDTH*LANE_BITS-1:0] send_data,
  output logic [CORE_SIZE-1:0]                      send_ok,
  input  logic [CORE_SIZE-1:0]                      recv_request,
  input  logic [CORE_SIZE*ADDR_SIZE-1:0]            recv_core_idx,
  output logic [CORE_SIZE-1:0]                      recv_ready,
`ifdef VEC_SWITCH_STATS_EN
  output logic [31:0]                               xfer_count,
  output logic [31:0]                               stall_count,
`endif
  output logic [SWITCH_WIDTH*LANE_BITS-1:0]         recv_data
);

  localparam int c_DW = SWITCH_WIDTH * LANE_BITS;

  typedef enum logic [0:0] {
    ST_ARB     = 1'b0,
    ST_DELIVER = 1'b1
  } state_t;

  state_t               r_state, w_state_nxt;
  logic [ADDR_SIZE-1:0] r_rr_ptr, w_rr_ptr_nxt;
  logic [ADDR_SIZE-1:0] r_src, w_src_nxt;
  logic [ADDR_SIZE-1:0] r_dst, w_dst_nxt;
  logic [c_DW-1:0]      r_recv_data, w_recv_data_nxt;

  logic [ADDR_SIZE-1:0] w_send_idx [CORE_SIZE];
  logic [ADDR_SIZE-1:0] w_recv_idx [CORE_SIZE];
  logic [c_DW-1:0]      w_send_vec [CORE_SIZE];
  logic [CORE_SIZE-1:0] w_match;
  logic                 w_found;
  logic [ADDR_SIZE-1:0] w_win_d;
  logic [ADDR_SIZE-1:0] w_win_s;
  logic [ADDR_SIZE:0]   w_sum;

  // Split the flat per-core buses into indexable slices
  generate
    for (genvar g = 0; g < CORE_SIZE; g++) begin : g_unpack
      assign w_send_idx[g] = send_core_idx[g*ADDR_SIZE +: ADDR_SIZE];
      assign w_recv_idx[g] = recv_core_idx[g*ADDR_SIZE +: ADDR_SIZE];
      assign w_send_vec[g] = send_data[g*c_DW +: c_DW];
    end
  endgenerate

  // Receiver d matches when its named source offers to d; out-of-range
  // indices compare unequal to every real core and so never match
  generate
    for (genvar d = 0; d < CORE_SIZE; d++) begin : g_match
      logic [CORE_SIZE-1:0] w_hit;
      for (genvar s = 0; s < CORE_SIZE; s++) begin : g_src
        assign w_hit[s] = (w_recv_idx[d] == ADDR_SIZE'(s)) && send_ready[s] &&
                          (w_send_idx[s] == ADDR_SIZE'(d));
      end
      assign w_match[d] = recv_request[d] && (|w_hit);
    end
  endgenerate

  // Rotating search from rr_ptr: first matching receiver wins
  always_comb begin
    w_found = 1'b0;
    w_win_d = '0;
    w_sum   = '0;
    for (int i = 0; i < CORE_SIZE; i++) begin
      w_sum = {1'b0, r_rr_ptr} + (ADDR_SIZE+1)'(i);
      if (w_sum >= (ADDR_SIZE+1)'(CORE_SIZE)) begin
        w_sum = w_sum - (ADDR_SIZE+1)'(CORE_SIZE);
      end
      if (!w_found && w_match[w_sum[ADDR_SIZE-1:0]]) begin
        w_found = 1'b1;
        w_win_d = w_sum[ADDR_SIZE-1:0];
      end
    end
    w_win_s = w_recv_idx[w_win_d];
  end

  // Next-state, pointer advance and payload capture
  always_comb begin
    w_state_nxt     = r_state;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_src_nxt       = r_src;
    w_dst_nxt       = r_dst;
    w_recv_data_nxt = r_recv_data;
    case (r_state)
      ST_ARB: begin
        if (w_found) begin
          w_state_nxt     = ST_DELIVER;
          w_src_nxt       = w_win_s;
          w_dst_nxt       = w_win_d;
          w_recv_data_nxt = w_send_vec[w_win_s];
          w_rr_ptr_nxt    = (w_win_d == ADDR_SIZE'(CORE_SIZE-1)) ? '0
                                                                 : w_win_d + ADDR_SIZE'(1);
        end
      end
      ST_DELIVER: w_state_nxt = ST_ARB;
      default:    w_state_nxt = ST_ARB;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_ARB;
      r_rr_ptr    <= '0;
      r_src       <= '0;
      r_dst       <= '0;
      r_recv_data <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_src       <= w_src_nxt;
      r_dst       <= w_dst_nxt;
      r_recv_data <= w_recv_data_nxt;
    end
  end

  // Completion pulses decoded from the latched pair, live only in DELIVER
  always_comb begin
    send_ok    = '0;
    recv_ready = '0;
    if (r_state == ST_DELIVER) begin
      send_ok    = CORE_SIZE'(1) << r_src;
      recv_ready = CORE_SIZE'(1) << r_dst;
    end
  end

  assign recv_data = r_recv_data;

`ifdef VEC_SWITCH_STATS_EN
  logic [31:0] r_xfer_count;
  logic [31:0] r_stall_count;

  // Transfer and stall counters, free-running with natural wrap
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_xfer_count  <= '0;
      r_stall_count <= '0;
    end else begin
      if (r_state == ST_DELIVER) begin
        r_xfer_count <= r_xfer_count + 32'd1;
      end
      if ((r_state == ST_ARB) && (|recv_request) && !w_found) begin
        r_stall_count <= r_stall_count + 32'd1;
      end
    end
  end

  assign xfer_count  = r_xfer_count;
  assign stall_count = r_stall_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vec_switch_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vec_switch_arbiter
// Brief    : Scoreboard bench for vec_switch_arbiter: directed scenarios
//            followed by randomized offers/requests, checked against a
//            behavioural matching/round-robin model.
// Options  : VEC_SWITCH_STATS_EN also checks the statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vec_switch_arbiter;

  localparam int N  = 4;
  localparam int SW = 16;
  localparam int LB = 32;
  localparam int A  = 2;
  localparam int DW = SW * LB;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    send_ready = '0;
  logic [N*A-1:0]  send_core_idx = '0;
  logic [N*DW-1:0] send_data = '0;
  logic [N-1:0]    send_ok;
  logic [N-1:0]    recv_request = '0;
  logic [N*A-1:0]  recv_core_idx = '0;
  logic [N-1:0]    recv_ready;
  logic [DW-1:0]   recv_data;
`ifdef VEC_SWITCH_STATS_EN
  logic [31:0]     xfer_count;
  logic [31:0]     stall_count;
`endif

  vec_switch_arbiter #(
    .CORE_SIZE(N), .SWITCH_WIDTH(SW), .LANE_BITS(LB)
  ) u_dut (
    .clock         (clock),
    .reset         (reset),
    .send_ready    (send_ready),
    .send_core_idx (send_core_idx),
    .send_data     (send_data),
    .send_ok       (send_ok),
    .recv_request  (recv_request),
    .recv_core_idx (recv_core_idx),
    .recv_ready    (recv_ready),
`ifdef VEC_SWITCH_STATS_EN
    .xfer_count    (xfer_count),
    .stall_count   (stall_count),
`endif
    .recv_data     (recv_data)
  );

  always #5 clock = ~clock;

  // Bench-side view of every core's offer and request
  bit            s_rdy [N];
  int            s_dst [N];
  logic [DW-1:0] s_dat [N];
  bit            r_req [N];
  int            r_src [N];
  bit            hold = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int            cyc;
    logic [N-1:0]  sok;
    logic [N-1:0]  rrdy;
    logic [DW-1:0] data;
  } exp_t;
  exp_t q[$];

  int          cyc = 0;
  int          m_rr = 0;
  bit          m_busy = 1'b0;
  int unsigned m_xfer = 0;
  int unsigned m_stall = 0;
  int          m_win_d, m_win_s, m_d, m_s;
  bit          m_any;

  task automatic chk_n(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_d(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_vec();
    logic [DW-1:0] v;
    for (int l = 0; l < SW; l++) v[l*LB +: LB] = $urandom;
    return v;
  endfunction

  function automatic logic [DW-1:0] fill(input logic [31:0] lane);
    logic [DW-1:0] v;
    for (int l = 0; l < SW; l++) v[l*LB +: LB] = lane;
    return v;
  endfunction

  task automatic apply();
    for (int c = 0; c < N; c++) begin
      send_ready[c]           = s_rdy[c];
      send_core_idx[c*A +: A] = A'(s_dst[c]);
      send_data[c*DW +: DW]   = s_dat[c];
      recv_request[c]         = r_req[c];
      recv_core_idx[c*A +: A] = A'(r_src[c]);
    end
  endtask

  task automatic clear_all();
    for (int c = 0; c < N; c++) begin
      s_rdy[c] = 1'b0; s_dst[c] = 0; s_dat[c] = '0;
      r_req[c] = 1'b0; r_src[c] = 0;
    end
    apply();
  endtask

  // One clock step; inputs change 1 time unit after the edge.
  // Completed parties drop their offer/request unless hold is set.
  task automatic tick();
    @(posedge clock);
    #1;
    if (!hold) begin
      for (int c = 0; c < N; c++) begin
        if (send_ok[c])    s_rdy[c] = 1'b0;
        if (recv_ready[c]) r_req[c] = 1'b0;
      end
    end
    apply();
  endtask

  task automatic wait_pulse(input string nm, output int n);
    n = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      n++;
      if (recv_ready != '0) return;
    end
    n_checks++;
    n_errors++;
    $display("FAIL %s: got no pulse within %0d cycles expected a pulse", nm, n);
  endtask

  // Reference model: each non-busy edge applies the matching rule over
  // receivers in round-robin order and predicts the following cycle's pulses
  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      m_rr = 0; m_busy = 1'b0; m_xfer = 0; m_stall = 0;
      q.delete();
    end else begin
      cyc++;
      if (m_busy) begin
        m_busy = 1'b0;
        m_xfer++;
      end else begin
        m_win_d = -1; m_win_s = 0; m_any = 1'b0;
        for (int i = 0; i < N; i++) begin
          m_d = (m_rr + i) % N;
          m_s = r_src[m_d];
          if (r_req[m_d]) m_any = 1'b1;
          if (m_win_d < 0 && r_req[m_d] && m_s < N && s_rdy[m_s] && s_dst[m_s] == m_d) begin
            m_win_d = m_d;
            m_win_s = m_s;
          end
        end
        if (m_win_d >= 0) begin
          q.push_back('{cyc: cyc, sok: N'(1) << m_win_s, rrdy: N'(1) << m_win_d,
                        data: s_dat[m_win_s]});
          m_rr   = (m_win_d + 1) % N;
          m_busy = 1'b1;
        end else if (m_any) begin
          m_stall++;
        end
      end
    end
  end

  // Monitor: compare DUT pulses and payload against the scoreboard
  initial forever begin
    logic [N-1:0]  e_s, e_r;
    logic [DW-1:0] e_d;
    bit            have;
    exp_t          e;
    @(negedge clock);
    if (!reset) begin
      e_s = '0; e_r = '0; e_d = '0; have = 1'b0;
      if (q.size() > 0 && q[0].cyc == cyc) begin
        e = q.pop_front();
        have = 1'b1; e_s = e.sok; e_r = e.rrdy; e_d = e.data;
      end
      chk_n("sb_send_ok", 32'(send_ok), 32'(e_s));
      chk_n("sb_recv_ready", 32'(recv_ready), 32'(e_r));
      if (have) chk_d("sb_recv_data", recv_data, e_d);
`ifdef VEC_SWITCH_STATS_EN
      chk_n("sb_xfer_count", xfer_count, m_xfer);
      chk_n("sb_stall_count", stall_count, m_stall);
`endif
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n1, n2, cnt;
    logic [31:0] base;
    base = '0;
    clear_all();

    // Reset state, with two round-robin pairs pending: 0->1 and 2->3
    s_rdy[0] = 1'b1; s_dst[0] = 1; s_dat[0] = rand_vec();
    r_req[1] = 1'b1; r_src[1] = 0;
    s_rdy[2] = 1'b1; s_dst[2] = 3; s_dat[2] = rand_vec();
    r_req[3] = 1'b1; r_src[3] = 2;
    apply();
    #12;
    chk_n("reset_send_ok", 32'(send_ok), 32'd0);
    chk_n("reset_recv_ready", 32'(recv_ready), 32'd0);
    chk_d("reset_recv_data", recv_data, '0);
`ifdef VEC_SWITCH_STATS_EN
    chk_n("reset_xfer_count", xfer_count, 32'd0);
    chk_n("reset_stall_count", stall_count, 32'd0);
`endif
    @(posedge clock);
    #1 reset = 1'b0;
    wait_pulse("rr_first", n1);
    chk_n("rr_first_recv", 32'(recv_ready), 32'b0010);
    chk_n("rr_first_send", 32'(send_ok), 32'b0001);
    chk_n("rr_first_lat", 32'(n1), 32'd1);
    wait_pulse("rr_second", n2);
    chk_n("rr_second_recv", 32'(recv_ready), 32'b1000);
    chk_n("rr_second_send", 32'(send_ok), 32'b0100);
    chk_n("rr_second_gap", 32'(n2), 32'd2);
    clear_all();
    repeat (3) tick();

    // Single transfer 1 -> 2
    s_rdy[1] = 1'b1; s_dst[1] = 2; s_dat[1] = fill(32'h3F800000);
    r_req[2] = 1'b1; r_src[2] = 1;
    apply();
    wait_pulse("single", n1);
    chk_n("single_lat", 32'(n1), 32'd1);
    chk_n("single_send_ok", 32'(send_ok), 32'b0010);
    chk_n("single_recv_ready", 32'(recv_ready), 32'b0100);
    chk_d("single_data", recv_data, fill(32'h3F800000));
    tick();
    chk_n("single_after_send", 32'(send_ok), 32'd0);
    chk_n("single_after_recv", 32'(recv_ready), 32'd0);
    clear_all();
    repeat (3) tick();

    // Mismatch: core0 offers to 3, core3 wants core1
    s_rdy[0] = 1'b1; s_dst[0] = 3; s_dat[0] = rand_vec();
    r_req[3] = 1'b1; r_src[3] = 1;
    apply();
`ifdef VEC_SWITCH_STATS_EN
    base = stall_count;
`endif
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (send_ok != '0 || recv_ready != '0) cnt++;
    end
    chk_n("mismatch_pulses", 32'(cnt), 32'd0);
`ifdef VEC_SWITCH_STATS_EN
    chk_n("mismatch_stalls", stall_count - base, 32'd20);
`endif
    clear_all();
    repeat (3) tick();

    // Loopback 2 -> 2
    s_rdy[2] = 1'b1; s_dst[2] = 2; s_dat[2] = fill(32'h40490FDB);
    r_req[2] = 1'b1; r_src[2] = 2;
    apply();
    wait_pulse("loop", n1);
    chk_n("loop_send_ok", 32'(send_ok), 32'b0100);
    chk_n("loop_recv_ready", 32'(recv_ready), 32'b0100);
    chk_d("loop_data", recv_data, fill(32'h40490FDB));
    clear_all();
    repeat (3) tick();

    // Reset during the pulse cycle, request held across reset
    hold = 1'b1;
    s_rdy[3] = 1'b1; s_dst[3] = 0; s_dat[3] = rand_vec();
    r_req[0] = 1'b1; r_src[0] = 3;
    apply();
    wait_pulse("rst_pre", n1);
    reset = 1'b1;
    #1;
    chk_n("rst_mid_send_ok", 32'(send_ok), 32'd0);
    chk_n("rst_mid_recv_ready", 32'(recv_ready), 32'd0);
    chk_d("rst_mid_data", recv_data, '0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    wait_pulse("rst_regrant", n1);
    chk_n("rst_regrant_lat", 32'(n1), 32'd1);
    chk_n("rst_regrant_send", 32'(send_ok), 32'b1000);
    chk_n("rst_regrant_recv", 32'(recv_ready), 32'b0001);
    hold = 1'b0;
    clear_all();
    repeat (3) tick();

    // Back-to-back 0 -> 1 with fresh data after each pulse
    hold = 1'b1;
    s_rdy[0] = 1'b1; s_dst[0] = 1; s_dat[0] = rand_vec();
    r_req[1] = 1'b1; r_src[1] = 0;
    apply();
`ifdef VEC_SWITCH_STATS_EN
    base = xfer_count;
`endif
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (recv_ready[1]) begin
        cnt++;
        s_dat[0] = rand_vec();
        apply();
      end
    end
    chk_n("b2b_pulses", 32'(cnt), 32'd6);
`ifdef VEC_SWITCH_STATS_EN
    chk_n("b2b_xfers", xfer_count - base, 32'd6);
`endif
    hold = 1'b0;
    clear_all();
    repeat (3) tick();

    // Randomized offers, requests and withdrawals
    for (int t = 0; t < 3000; t++) begin
      tick();
      for (int c = 0; c < N; c++) begin
        if (!s_rdy[c]) begin
          if ($urandom_range(3) == 0) begin
            s_rdy[c] = 1'b1;
            s_dst[c] = int'($urandom_range(N-1));
            s_dat[c] = rand_vec();
          end
        end else if (!send_ok[c] && $urandom_range(31) == 0) begin
          s_rdy[c] = 1'b0;
        end
        if (!r_req[c]) begin
          if ($urandom_range(3) == 0) begin
            r_req[c] = 1'b1;
            r_src[c] = int'($urandom_range(N-1));
            if ($urandom_range(1) == 1) begin
              for (int s = 0; s < N; s++) begin
                if (s_rdy[s] && s_dst[s] == c) r_src[c] = s;
              end
            end
          end
        end else if (!recv_ready[c] && $urandom_range(15) == 0) begin
          r_req[c] = 1'b0;
        end
      end
      apply();
    end

    clear_all();
    repeat (4) tick();
    chk_n("queue_drain", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
